// File: rtl/zoom_executor.sv
// Zoom pass engine: walks the source frame for the latched ALGORITHM code and
// writes the 2x-enlarged or 2x-reduced image row-major into destination memory.
module zoom_executor #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 17
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [1:0]        ALGORITHM,
    output logic              SRC_RD,
    output logic [SRC_AW-1:0] SRC_ADDR,
    input  logic [PIX_W-1:0]  SRC_DATA,
    output logic              DST_WE,
    output logic [DST_AW-1:0] DST_ADDR,
    output logic [PIX_W-1:0]  DST_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        OUT_STATE
);

    localparam int CW    = $clog2(2 * SRC_W);
    localparam int RW    = $clog2(2 * SRC_H);
    localparam int ACC_W = PIX_W + 2;

    localparam logic [1:0] ALG_NN = 2'd0;
    localparam logic [1:0] ALG_PR = 2'd1;
    localparam logic [1:0] ALG_DC = 2'd2;
    localparam logic [1:0] ALG_BA = 2'd3;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    state_t          state, state_nx;
    logic [1:0]      alg, alg_nx;
    logic [CW-1:0]   cx, cx_nx, x_max;
    logic [RW-1:0]   cy, cy_nx, y_max;
    logic [1:0]      sub, sub_nx;
    logic [1:0]      out_state, out_state_nx;

    logic             vld_p1;
    logic [PIX_W-1:0] pix_p1;
    logic [ACC_W-1:0] acc_p1;

    logic [31:0]       sx, sy, dx, dy, dw;
    logic [SRC_AW-1:0] src_lin;
    logic [DST_AW-1:0] dst_lin;
    logic [PIX_W-1:0]  wr_data;

    // 2x2 box average with round-half-up; the sum plus bias fits ACC_W bits.
    function automatic logic [PIX_W-1:0] round_avg4(input logic [ACC_W-1:0] sum);
        return PIX_W'((sum + ACC_W'(2)) >> 2);
    endfunction

    always_comb begin
        x_max = CW'(SRC_W / 2 - 1);
        y_max = RW'(SRC_H / 2 - 1);
        case (alg)
            ALG_NN: begin
                x_max = CW'(2 * SRC_W - 1);
                y_max = RW'(2 * SRC_H - 1);
            end
            ALG_PR: begin
                x_max = CW'(SRC_W - 1);
                y_max = RW'(SRC_H - 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            alg       <= ALG_NN;
            cx        <= '0;
            cy        <= '0;
            sub       <= '0;
            out_state <= 2'd0;
            vld_p1    <= 1'b0;
        end else begin
            state     <= state_nx;
            alg       <= alg_nx;
            cx        <= cx_nx;
            cy        <= cy_nx;
            sub       <= sub_nx;
            out_state <= out_state_nx;
            vld_p1    <= (state == RD);
        end
    end

    always_comb begin
        state_nx     = state;
        alg_nx       = alg;
        cx_nx        = cx;
        cy_nx        = cy;
        sub_nx       = sub;
        out_state_nx = out_state;
        case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (START) begin
                    alg_nx   = ALGORITHM;
                    cx_nx    = '0;
                    cy_nx    = '0;
                    sub_nx   = '0;
                    state_nx = RD;
                end
            end
            RD: begin
                if (alg == ALG_BA) begin
                    if (sub == 2'd3) begin
                        sub_nx   = '0;
                        state_nx = CAP;
                    end else begin
                        sub_nx = sub + 2'd1;
                    end
                end else begin
                    state_nx = WR;
                end
            end
            CAP: state_nx = WR;
            WR: begin
                // PR fans one read out to its 2x2 block before advancing
                if (alg == ALG_PR && sub != 2'd3) begin
                    sub_nx = sub + 2'd1;
                end else begin
                    sub_nx = '0;
                    if (cx == x_max) begin
                        cx_nx = '0;
                        if (cy == y_max) begin
                            cy_nx        = '0;
                            state_nx     = FIN;
                            out_state_nx = (alg == ALG_NN || alg == ALG_PR) ? 2'd1 : 2'd2;
                        end else begin
                            cy_nx    = cy + RW'(1);
                            state_nx = RD;
                        end
                    end else begin
                        cx_nx    = cx + CW'(1);
                        state_nx = RD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sx = 32'(cx);
        sy = 32'(cy);
        dx = 32'(cx);
        dy = 32'(cy);
        dw = 32'(SRC_W / 2);
        case (alg)
            ALG_NN: begin
                sx = 32'(cx) >> 1;
                sy = 32'(cy) >> 1;
                dw = 32'(2 * SRC_W);
            end
            ALG_PR: begin
                dx = 2 * 32'(cx) + 32'(sub[0]);
                dy = 2 * 32'(cy) + 32'(sub[1]);
                dw = 32'(2 * SRC_W);
            end
            ALG_DC: begin
                sx = 2 * 32'(cx);
                sy = 2 * 32'(cy);
            end
            default: begin
                sx = 2 * 32'(cx) + 32'(sub[0]);
                sy = 2 * 32'(cy) + 32'(sub[1]);
            end
        endcase
        src_lin = SRC_AW'(sy * 32'(SRC_W) + sx);
        dst_lin = DST_AW'(dy * dw + dx);
    end

    // stage p1: read data returns one cycle after SRC_RD; hold it and sum it
    always_ff @(posedge CLK) begin
        if (vld_p1) pix_p1 <= SRC_DATA;
        acc_p1 <= vld_p1 ? acc_p1 + ACC_W'(SRC_DATA) : '0;
    end

    always_comb begin
        if (alg == ALG_BA)  wr_data = round_avg4(acc_p1);
        else if (vld_p1)    wr_data = SRC_DATA;
        else                wr_data = pix_p1;
    end

    assign SRC_RD    = (state == RD);
    assign DST_WE    = (state == WR);
    assign BUSY      = (state == RD) || (state == CAP) || (state == WR);
    assign DONE      = (state == FIN);
    assign OUT_STATE = out_state;
    assign SRC_ADDR  = SRC_RD ? src_lin : '0;
    assign DST_ADDR  = DST_WE ? dst_lin : '0;
    assign DST_DATA  = DST_WE ? wr_data : '0;

endmodule

// File: tb/tb_zoom_executor.sv
// Directed bench for zoom_executor: 4x4 frame for all algorithms and protocol,
// plus a 2x2 instance for the single-block BA case.
module tb_zoom_executor;

    localparam int PIX_W  = 8;
    localparam int SRC_AW = 15;
    localparam int DST_AW = 17;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              START;
    logic [1:0]        ALGORITHM;
    logic              SRC_RD;
    logic [SRC_AW-1:0] SRC_ADDR;
    logic [PIX_W-1:0]  SRC_DATA;
    logic              DST_WE;
    logic [DST_AW-1:0] DST_ADDR;
    logic [PIX_W-1:0]  DST_DATA;
    logic              BUSY;
    logic              DONE;
    logic [1:0]        OUT_STATE;

    logic              b_start;
    logic [1:0]        b_alg;
    logic              b_src_rd;
    logic [SRC_AW-1:0] b_src_addr;
    logic [PIX_W-1:0]  b_src_data;
    logic              b_dst_we;
    logic [DST_AW-1:0] b_dst_addr;
    logic [PIX_W-1:0]  b_dst_data;
    logic              b_busy;
    logic              b_done;
    logic [1:0]        b_out_state;

    always #5 CLK = ~CLK;

    zoom_executor #(.SRC_W(4), .SRC_H(4), .PIX_W(PIX_W), .SRC_AW(SRC_AW), .DST_AW(DST_AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ALGORITHM(ALGORITHM),
        .SRC_RD(SRC_RD), .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
        .DST_WE(DST_WE), .DST_ADDR(DST_ADDR), .DST_DATA(DST_DATA),
        .BUSY(BUSY), .DONE(DONE), .OUT_STATE(OUT_STATE)
    );

    zoom_executor #(.SRC_W(2), .SRC_H(2), .PIX_W(PIX_W), .SRC_AW(SRC_AW), .DST_AW(DST_AW)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .START(b_start), .ALGORITHM(b_alg),
        .SRC_RD(b_src_rd), .SRC_ADDR(b_src_addr), .SRC_DATA(b_src_data),
        .DST_WE(b_dst_we), .DST_ADDR(b_dst_addr), .DST_DATA(b_dst_data),
        .BUSY(b_busy), .DONE(b_done), .OUT_STATE(b_out_state)
    );

    logic [7:0]  src_mem [0:15];
    logic [7:0]  dst_mem [0:63];
    logic [31:0] wr_addr_log [0:1023];
    logic [7:0]  wr_data_log [0:1023];
    logic [7:0]  b_src_mem [0:3];
    int          wr_cnt = 0;
    int          b_wr_cnt = 0;
    logic [31:0] b_last_addr = 32'hFFFF_FFFF;
    logic [7:0]  b_last_data = 8'h00;
    logic        clr_dst = 1'b0;
    int          cyc = 0;
    int          overlap = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          t0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) if (SRC_RD) SRC_DATA <= src_mem[SRC_ADDR[3:0]];
    always @(posedge CLK) if (b_src_rd) b_src_data <= b_src_mem[b_src_addr[1:0]];

    always @(posedge CLK) begin
        if (clr_dst) begin
            for (int k = 0; k < 64; k++) dst_mem[k] <= 8'hEE;
        end else if (DST_WE) begin
            dst_mem[DST_ADDR[5:0]]      <= DST_DATA;
            wr_addr_log[wr_cnt[9:0]]    <= 32'(DST_ADDR);
            wr_data_log[wr_cnt[9:0]]    <= DST_DATA;
            wr_cnt                      <= wr_cnt + 1;
        end
    end

    always @(posedge CLK) begin
        if (b_dst_we) begin
            b_last_addr <= 32'(b_dst_addr);
            b_last_data <= b_dst_data;
            b_wr_cnt    <= b_wr_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        if ((SRC_RD && DST_WE) || (b_src_rd && b_dst_we)) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of relative cycle 1.
    task automatic start_pass(input logic [1:0] alg);
        START = 1'b1;
        ALGORITHM = alg;
        t0 = cyc;
        @(negedge CLK);
        START = 1'b0;
        check("busy_cycle1", 32'(BUSY), 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (DONE === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic clear_dst();
        clr_dst = 1'b1;
        @(negedge CLK);
        clr_dst = 1'b0;
    endtask

    function automatic logic [7:0] enlarge_ref(input int a);
        int x, y;
        x = a % 8;
        y = a / 8;
        return src_mem[(y / 2) * 4 + (x / 2)];
    endfunction

    int lat, w0, errs, found;
    logic [7:0] exp4 [0:3];

    initial begin
        RESET_N = 1'b0; START = 1'b0; ALGORITHM = 2'd0;
        b_start = 1'b0; b_alg = 2'd0;
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        b_src_mem[0] = 8'd10; b_src_mem[1] = 8'd20; b_src_mem[2] = 8'd30; b_src_mem[3] = 8'd41;
        repeat (3) @(negedge CLK);

        check("rst_src_rd",    32'(SRC_RD),    32'd0);
        check("rst_dst_we",    32'(DST_WE),    32'd0);
        check("rst_busy",      32'(BUSY),      32'd0);
        check("rst_done",      32'(DONE),      32'd0);
        check("rst_out_state", 32'(OUT_STATE), 32'd0);
        check("rst_src_addr",  32'(SRC_ADDR),  32'd0);
        check("rst_dst_addr",  32'(DST_ADDR),  32'd0);
        check("rst_dst_data",  32'(DST_DATA),  32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // NN enlarge
        clear_dst();
        w0 = wr_cnt;
        start_pass(2'd0);
        wait_done(lat);
        check("nn_latency",   32'(lat), 32'd129);
        check("nn_out_state", 32'(OUT_STATE), 32'd1);
        check("nn_busy_done", 32'(BUSY), 32'd0);
        check("nn_writes",    32'(wr_cnt - w0), 32'd64);
        errs = 0;
        for (int i = 0; i < 64; i++) if (wr_addr_log[w0 + i] !== 32'(i)) errs++;
        check("nn_order", 32'(errs), 32'd0);
        errs = 0;
        for (int i = 0; i < 64; i++) if (dst_mem[i] !== enlarge_ref(i)) errs++;
        check("nn_image", 32'(errs), 32'd0);
        check("nn_dst9",  32'(dst_mem[9]),  32'd0);
        check("nn_dst27", 32'(dst_mem[27]), 32'd5);
        check("nn_dst63", 32'(dst_mem[63]), 32'd15);
        @(negedge CLK);
        check("nn_done_pulse", 32'(DONE), 32'd0);

        // PR enlarge
        clear_dst();
        w0 = wr_cnt;
        start_pass(2'd1);
        wait_done(lat);
        check("pr_latency",   32'(lat), 32'd81);
        check("pr_writes",    32'(wr_cnt - w0), 32'd64);
        check("pr_wr0_addr",  wr_addr_log[w0],     32'd0);
        check("pr_wr1_addr",  wr_addr_log[w0 + 1], 32'd1);
        check("pr_wr2_addr",  wr_addr_log[w0 + 2], 32'd8);
        check("pr_wr3_addr",  wr_addr_log[w0 + 3], 32'd9);
        errs = 0;
        for (int i = 0; i < 4; i++) if (wr_data_log[w0 + i] !== 8'd0) errs++;
        check("pr_first_data", 32'(errs), 32'd0);
        errs = 0;
        for (int i = 0; i < 64; i++) if (dst_mem[i] !== enlarge_ref(i)) errs++;
        check("pr_image",     32'(errs), 32'd0);
        check("pr_out_state", 32'(OUT_STATE), 32'd1);
        @(negedge CLK);

        // DC reduce
        clear_dst();
        w0 = wr_cnt;
        start_pass(2'd2);
        wait_done(lat);
        exp4[0] = 8'd0; exp4[1] = 8'd2; exp4[2] = 8'd8; exp4[3] = 8'd10;
        check("dc_latency",   32'(lat), 32'd9);
        check("dc_writes",    32'(wr_cnt - w0), 32'd4);
        check("dc_out_state", 32'(OUT_STATE), 32'd2);
        for (int k = 0; k < 4; k++) check($sformatf("dc_dst%0d", k), 32'(dst_mem[k]), 32'(exp4[k]));
        @(negedge CLK);

        // BA reduce
        clear_dst();
        w0 = wr_cnt;
        start_pass(2'd3);
        wait_done(lat);
        exp4[0] = 8'd3; exp4[1] = 8'd5; exp4[2] = 8'd11; exp4[3] = 8'd13;
        check("ba_latency",   32'(lat), 32'd25);
        check("ba_writes",    32'(wr_cnt - w0), 32'd4);
        check("ba_out_state", 32'(OUT_STATE), 32'd2);
        for (int k = 0; k < 4; k++) check($sformatf("ba_dst%0d", k), 32'(dst_mem[k]), 32'(exp4[k]));
        @(negedge CLK);

        // BA rounding at the top and bottom of the range
        src_mem[0] = 8'd255; src_mem[1] = 8'd255; src_mem[4] = 8'd255; src_mem[5] = 8'd254;
        src_mem[2] = 8'd0;   src_mem[3] = 8'd0;   src_mem[6] = 8'd1;   src_mem[7] = 8'd1;
        clear_dst();
        start_pass(2'd3);
        wait_done(lat);
        check("round_hi",  32'(dst_mem[0]), 32'd255);
        check("round_lo",  32'(dst_mem[1]), 32'd1);
        check("round_blk2", 32'(dst_mem[2]), 32'd11);
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        @(negedge CLK);

        // START pulses and ALGORITHM toggling while busy
        clear_dst();
        w0 = wr_cnt;
        start_pass(2'd3);
        lat = -1;
        for (int c = 1; c < 3000; c++) begin
            if (DONE === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            START = (c == 3 || c == 10 || c == 17);
            ALGORITHM = 2'(c);
            @(negedge CLK);
        end
        START = 1'b0;
        exp4[0] = 8'd3; exp4[1] = 8'd5; exp4[2] = 8'd11; exp4[3] = 8'd13;
        check("prot_latency", 32'(lat), 32'd25);
        check("prot_writes",  32'(wr_cnt - w0), 32'd4);
        check("prot_out_state", 32'(OUT_STATE), 32'd2);
        for (int k = 0; k < 4; k++) check($sformatf("prot_dst%0d", k), 32'(dst_mem[k]), 32'(exp4[k]));

        // START in the DONE cycle starts a DC pass straight away
        w0 = wr_cnt;
        start_pass(2'd2);
        wait_done(lat);
        exp4[0] = 8'd0; exp4[1] = 8'd2; exp4[2] = 8'd8; exp4[3] = 8'd10;
        check("b2b_latency", 32'(lat), 32'd9);
        check("b2b_writes",  32'(wr_cnt - w0), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("b2b_dst%0d", k), 32'(dst_mem[k]), 32'(exp4[k]));
        @(negedge CLK);

        // Reset during the 10th write of an NN pass
        w0 = wr_cnt;
        start_pass(2'd0);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            if (DST_WE === 1'b1 && wr_cnt - w0 == 9) begin
                found = 1;
                break;
            end
            @(negedge CLK);
        end
        check("rst_reach_10th", 32'(found), 32'd1);
        #1 RESET_N = 1'b0;
        #1;
        check("mid_src_rd",    32'(SRC_RD),    32'd0);
        check("mid_dst_we",    32'(DST_WE),    32'd0);
        check("mid_busy",      32'(BUSY),      32'd0);
        check("mid_done",      32'(DONE),      32'd0);
        check("mid_out_state", 32'(OUT_STATE), 32'd0);
        check("mid_dst_addr",  32'(DST_ADDR),  32'd0);
        check("mid_dst_data",  32'(DST_DATA),  32'd0);
        repeat (3) @(negedge CLK);
        check("mid_no_write", 32'(wr_cnt - w0), 32'd9);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("mid_no_resume_busy",  32'(BUSY), 32'd0);
        check("mid_no_resume_write", 32'(wr_cnt - w0), 32'd9);
        start_pass(2'd2);
        wait_done(lat);
        check("post_rst_latency",   32'(lat), 32'd9);
        check("post_rst_out_state", 32'(OUT_STATE), 32'd2);
        for (int k = 0; k < 4; k++) check($sformatf("post_rst_dst%0d", k), 32'(dst_mem[k]), 32'(exp4[k]));
        @(negedge CLK);

        // 2x2 source with BA: a single output pixel
        b_start = 1'b1;
        b_alg = 2'd3;
        t0 = cyc;
        @(negedge CLK);
        b_start = 1'b0;
        b_alg = 2'd0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (b_done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge CLK);
        end
        check("bound_latency",   32'(lat), 32'd7);
        check("bound_writes",    32'(b_wr_cnt), 32'd1);
        check("bound_addr",      b_last_addr, 32'd0);
        check("bound_data",      32'(b_last_data), 32'd25);
        check("bound_out_state", 32'(b_out_state), 32'd2);
        @(negedge CLK);

        check("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
